// File: rtl/conv_os_engine.sv
// Output-stationary convolution engine: one accumulator, one oFM write per output pixel.
// Latency: N*K*K+2 cycles per pixel; M*OFM_R*OFM_C*(N*K*K+2) cycles from RUN entry to DONE.
// Backpressure: none; BRAM reads have a fixed 1-cycle latency, and start/done is a level handshake with the PS.
module conv_os_engine #(
  parameter int DATA_W = 32,
  parameter int M      = 3,
  parameter int N      = 3,
  parameter int K      = 3,
  parameter int IFM_R  = 4,
  parameter int IFM_C  = 4,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ps_control,
  output logic [31:0]       pl_status,
  output logic [31:0]       iFM_addr,
  input  logic [DATA_W-1:0] iFM_rddata,
  output logic [DATA_W-1:0] iFM_wrdata,
  output logic [3:0]        iFM_we,
  output logic [31:0]       kernel_addr,
  input  logic [DATA_W-1:0] kernel_rddata,
  output logic [DATA_W-1:0] kernel_wrdata,
  output logic [3:0]        kernel_we,
  output logic [31:0]       oFM_addr,
  input  logic [DATA_W-1:0] oFM_rddata,
  output logic [DATA_W-1:0] oFM_wrdata,
  output logic [3:0]        oFM_we
);

  localparam int OFM_R = (IFM_R - K) / STRIDE + 1;
  localparam int OFM_C = (IFM_C - K) / STRIDE + 1;
  localparam int MW    = (M > 1) ? $clog2(M) : 1;
  localparam int NW    = (N > 1) ? $clog2(N) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int RW    = (OFM_R > 1) ? $clog2(OFM_R) : 1;
  localparam int CW    = (OFM_C > 1) ? $clog2(OFM_C) : 1;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [MW-1:0]     cnt_m;
  logic [RW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_c;
  logic [NW-1:0]     cnt_n;
  logic [KW-1:0]     cnt_kr, cnt_kc;
  logic [15:0]       pix_cnt;
  logic              relu_latched;
  logic              valid_d, first_d;
  logic [DATA_W-1:0] acc;
  logic              start;
  logic              last_kc, last_kr, last_n, last_tap;
  logic              last_c, last_r, last_m, last_pix;
  logic              unused_bits;

  assign start = ps_control[0];

  // Read-only ports on the feature map and kernel memories.
  assign iFM_wrdata    = '0;
  assign iFM_we        = '0;
  assign kernel_wrdata = '0;
  assign kernel_we     = '0;
  assign unused_bits   = ^{oFM_rddata, ps_control[31:2]};

  assign last_kc  = (int'(cnt_kc) == K - 1);
  assign last_kr  = (int'(cnt_kr) == K - 1);
  assign last_n   = (int'(cnt_n) == N - 1);
  assign last_tap = last_kc && last_kr && last_n;
  assign last_c   = (int'(cnt_c) == OFM_C - 1);
  assign last_r   = (int'(cnt_r) == OFM_R - 1);
  assign last_m   = (int'(cnt_m) == M - 1);
  assign last_pix = last_c && last_r && last_m;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, status and write-port outputs.
  always_comb begin
    state_nxt  = state;
    oFM_we     = 4'h0;
    oFM_wrdata = '0;
    pl_status  = {pix_cnt, 14'b0, 1'b0, 1'b0};
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        pl_status[1] = 1'b1;
        if (last_tap) state_nxt = DRAIN;
      end
      DRAIN: begin
        pl_status[1] = 1'b1;
        state_nxt    = WRITE;
      end
      WRITE: begin
        pl_status[1] = 1'b1;
        oFM_we       = 4'hF;
        oFM_wrdata   = (relu_latched && acc[DATA_W-1]) ? '0 : acc;
        state_nxt    = last_pix ? DONE : RUN;
      end
      DONE: begin
        pl_status[0] = 1'b1;
        if (!start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Loop counters: taps advance in RUN (kc fastest), pixels advance in WRITE (c fastest).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_m        <= '0;
      cnt_r        <= '0;
      cnt_c        <= '0;
      cnt_n        <= '0;
      cnt_kr       <= '0;
      cnt_kc       <= '0;
      pix_cnt      <= '0;
      relu_latched <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt_m        <= '0;
          cnt_r        <= '0;
          cnt_c        <= '0;
          cnt_n        <= '0;
          cnt_kr       <= '0;
          cnt_kc       <= '0;
          pix_cnt      <= '0;
          relu_latched <= ps_control[1];
        end
        RUN: begin
          cnt_kc <= last_kc ? '0 : cnt_kc + 1'b1;
          if (last_kc) begin
            cnt_kr <= last_kr ? '0 : cnt_kr + 1'b1;
            if (last_kr) cnt_n <= last_n ? '0 : cnt_n + 1'b1;
          end
        end
        WRITE: begin
          pix_cnt <= pix_cnt + 16'd1;
          cnt_c   <= last_c ? '0 : cnt_c + 1'b1;
          if (last_c) begin
            cnt_r <= last_r ? '0 : cnt_r + 1'b1;
            if (last_r) cnt_m <= last_m ? '0 : cnt_m + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // MAC: read data arrives one cycle after its address, so valid/first trail the issue by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d <= 1'b0;
      first_d <= 1'b0;
      acc     <= '0;
    end else begin
      valid_d <= (state == RUN);
      first_d <= (state == RUN) && (cnt_n == '0) && (cnt_kr == '0) && (cnt_kc == '0);
      if (valid_d) acc <= (first_d ? '0 : acc) + iFM_rddata * kernel_rddata;
    end
  end

  // Byte addresses derived from the loop counters; oFM address holds for the whole pixel.
  always_comb begin
    iFM_addr    = '0;
    kernel_addr = '0;
    oFM_addr    = '0;
    if (state == RUN || state == DRAIN) begin
      iFM_addr    = 4 * (int'(cnt_n) * IFM_R * IFM_C
                         + (int'(cnt_r) * STRIDE + int'(cnt_kr)) * IFM_C
                         + int'(cnt_c) * STRIDE + int'(cnt_kc));
      kernel_addr = 4 * (((int'(cnt_m) * N + int'(cnt_n)) * K + int'(cnt_kr)) * K + int'(cnt_kc));
    end
    if (state == RUN || state == DRAIN || state == WRITE)
      oFM_addr = 4 * (int'(cnt_m) * OFM_R * OFM_C + int'(cnt_r) * OFM_C + int'(cnt_c));
  end

endmodule

// File: tb/tb_conv_os_engine.sv
// Bench for conv_os_engine: default 3x3x3 config plus a 5x5 stride-2 single-channel config.
// Table-driven data patterns, randomized data runs, reset/start corner sequences.
// Expected outputs come from a direct nested-loop evaluation of the convolution sum.
module tb_conv_os_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance signals
  logic [31:0] ps0, st0, ia0, ka0, oa0, iwd0, kwd0, owd0;
  logic [31:0] ird0, krd0;
  logic [3:0]  iwe0, kwe0, owe0;
  // Stride-2 instance signals
  logic [31:0] ps2, st2, ia2, ka2, oa2, iwd2, kwd2, owd2;
  logic [31:0] ird2, krd2;
  logic [3:0]  iwe2, kwe2, owe2;

  conv_os_engine dut0 (
    .clk(clk), .reset(reset), .ps_control(ps0), .pl_status(st0),
    .iFM_addr(ia0), .iFM_rddata(ird0), .iFM_wrdata(iwd0), .iFM_we(iwe0),
    .kernel_addr(ka0), .kernel_rddata(krd0), .kernel_wrdata(kwd0), .kernel_we(kwe0),
    .oFM_addr(oa0), .oFM_rddata(32'h0), .oFM_wrdata(owd0), .oFM_we(owe0)
  );

  conv_os_engine #(.DATA_W(32), .M(1), .N(1), .K(3), .IFM_R(5), .IFM_C(5), .STRIDE(2)) dut2 (
    .clk(clk), .reset(reset), .ps_control(ps2), .pl_status(st2),
    .iFM_addr(ia2), .iFM_rddata(ird2), .iFM_wrdata(iwd2), .iFM_we(iwe2),
    .kernel_addr(ka2), .kernel_rddata(krd2), .kernel_wrdata(kwd2), .kernel_we(kwe2),
    .oFM_addr(oa2), .oFM_rddata(32'h0), .oFM_wrdata(owd2), .oFM_we(owe2)
  );

  // BRAM models
  int ifm0[64], ker0[64], ifm2[64], ker2[64];
  logic [31:0] ofm0[16], ofm2[16];
  int wr0 = 0, wr2 = 0, cyc = 0;
  bit clr = 1'b0;
  bit bad_we = 1'b0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    ird0 <= ifm0[ia0[7:2]];
    krd0 <= ker0[ka0[7:2]];
    ird2 <= ifm2[ia2[7:2]];
    krd2 <= ker2[ka2[7:2]];
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        ofm0[i] <= 32'hDEADBEEF;
        ofm2[i] <= 32'hDEADBEEF;
      end
    end else begin
      if (owe0 == 4'hF) begin ofm0[oa0[5:2]] <= owd0; wr0 <= wr0 + 1; end
      if (owe2 == 4'hF) begin ofm2[oa2[5:2]] <= owd2; wr2 <= wr2 + 1; end
    end
    if ((owe0 != 4'h0 && owe0 != 4'hF) || (owe2 != 4'h0 && owe2 != 4'hF)) bad_we <= 1'b1;
  end

  // First iFM address seen for stride-2 output pixel (1,1)
  bit          cap_done = 1'b0;
  logic [31:0] cap_addr = 32'h0;
  always @(negedge clk) begin
    if (!cap_done && st2[1] && oa2 == 32'd12) begin
      cap_addr = ia2;
      cap_done = 1'b1;
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, act, $signed(act), exp, $signed(exp));
    end
  endtask

  // Reference: direct evaluation of the convolution sum with 32-bit wrapping arithmetic.
  function automatic int ref_o(input bit sel, input int m, input int r, input int c, input bit relu);
    int ir, nn, st, s, iv, kv;
    ir = sel ? 5 : 4;
    nn = sel ? 1 : 3;
    st = sel ? 2 : 1;
    s  = 0;
    for (int n = 0; n < nn; n++)
      for (int kr = 0; kr < 3; kr++)
        for (int kc = 0; kc < 3; kc++) begin
          iv = sel ? ifm2[n*ir*ir + (r*st+kr)*ir + c*st+kc] : ifm0[n*ir*ir + (r*st+kr)*ir + c*st+kc];
          kv = sel ? ker2[((m*nn+n)*3+kr)*3+kc] : ker0[((m*nn+n)*3+kr)*3+kc];
          s  = s + iv * kv;
        end
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic cmp_out0(input bit relu, input string tag);
    for (int i = 0; i < 12; i++)
      check($sformatf("%s ofm[%0d]", tag, i), ofm0[i], ref_o(1'b0, i / 4, (i % 4) / 2, i % 2, relu));
  endtask

  // Full default run. drop_at < 0: hold start through DONE, then release it.
  task automatic run0(input bit relu, input int drop_at, input string tag);
    int t0, k, w0;
    w0 = wr0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ps0 = {30'b0, relu, 1'b1};
    k = 0;
    while (!st0[1] && k < 10) begin @(negedge clk); k++; end
    if (!st0[1]) begin
      check({tag, " busy_timeout"}, 32'h0, 32'h1);
      ps0 = '0;
      return;
    end
    t0 = cyc;
    k = 0;
    while (!st0[0] && k < 2000) begin
      if (cyc - t0 == drop_at) ps0[0] = 1'b0;
      if (cyc - t0 == 50) ps0[1] = ~relu;
      @(negedge clk);
      k++;
    end
    check({tag, " done_latency"}, cyc - t0, 348);
    check({tag, " pix_cnt"}, {16'h0, st0[31:16]}, 32'd12);
    check({tag, " writes"}, wr0 - w0, 12);
    if (drop_at >= 0) begin
      @(negedge clk);
      check({tag, " done_one_cycle"}, {30'h0, st0[1:0]}, 32'h0);
      repeat (20) @(negedge clk);
      check({tag, " no_retrigger"}, {30'h0, st0[1:0]}, 32'h0);
      check({tag, " writes_after"}, wr0 - w0, 12);
    end else begin
      repeat (5) @(negedge clk);
      check({tag, " done_hold"}, {30'h0, st0[1:0]}, 32'h1);
      ps0 = '0;
      @(negedge clk);
      check({tag, " idle_after_release"}, {30'h0, st0[1:0]}, 32'h0);
      check({tag, " pix_cnt_hold"}, {16'h0, st0[31:16]}, 32'd12);
    end
    ps0 = '0;
    cmp_out0(relu, tag);
  endtask

  typedef struct {
    int ifm_val;
    bit ifm_idx;
    int k_val;
    bit relu;
    bit uniform;
    int exp_val;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int k, t0;
    vecs[0] = '{ifm_val: 1, ifm_idx: 1'b0, k_val:  1, relu: 1'b0, uniform: 1'b1, exp_val:  27};
    vecs[1] = '{ifm_val: 0, ifm_idx: 1'b1, k_val:  1, relu: 1'b0, uniform: 1'b0, exp_val: 567};
    vecs[2] = '{ifm_val: 2, ifm_idx: 1'b0, k_val: -1, relu: 1'b0, uniform: 1'b1, exp_val: -54};
    vecs[3] = '{ifm_val: 2, ifm_idx: 1'b0, k_val: -1, relu: 1'b1, uniform: 1'b1, exp_val:   0};
    vecs[4] = '{ifm_val: 1, ifm_idx: 1'b0, k_val:  1, relu: 1'b1, uniform: 1'b1, exp_val:  27};

    ps0 = '0;
    ps2 = '0;
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin ifm0[i] = 0; ker0[i] = 0; ifm2[i] = 0; ker2[i] = 0; end
    repeat (3) @(negedge clk);
    check("reset pl_status", st0, 32'h0);
    check("reset oFM_we", {28'h0, owe0}, 32'h0);
    check("reset addrs", ia0 | ka0 | oa0, 32'h0);
    check("reset oFM_wrdata", owd0, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven data patterns
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 64; i++) begin
        ifm0[i] = vecs[v].ifm_idx ? i : vecs[v].ifm_val;
        ker0[i] = vecs[v].k_val;
      end
      run0(vecs[v].relu, -1, $sformatf("vec%0d", v));
      for (int i = 0; i < 12; i++)
        if (vecs[v].uniform || (i % 4 == 0))
          check($sformatf("vec%0d const[%0d]", v, i), ofm0[i], vecs[v].exp_val);
      repeat (3) @(negedge clk);
    end

    // Randomized data
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 64; i++) begin
        ifm0[i] = (t < 2) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
        ker0[i] = (t < 2) ? int'($urandom) : int'($urandom_range(0, 20)) - 10;
      end
      run0(1'($urandom_range(0, 1)), -1, $sformatf("rand%0d", t));
      repeat (2) @(negedge clk);
    end

    // Reset at RUN cycle 100 aborts the run
    ps0 = 32'h1;
    k = 0;
    while (!st0[1] && k < 10) begin @(negedge clk); k++; end
    repeat (100) @(negedge clk);
    reset = 1'b1;
    ps0 = '0;
    @(negedge clk);
    check("abort pl_status", st0, 32'h0);
    check("abort oFM_we", {28'h0, owe0}, 32'h0);
    reset = 1'b0;
    k = wr0;
    repeat (10) @(negedge clk);
    check("abort no_writes", wr0 - k, 0);
    check("abort idle", {30'h0, st0[1:0]}, 32'h0);
    for (int i = 0; i < 64; i++) begin ifm0[i] = int'($urandom_range(0, 50)); ker0[i] = int'($urandom_range(0, 9)) - 4; end
    run0(1'b0, -1, "after_abort");

    // Start dropped at RUN cycle 10
    run0(1'b0, 10, "drop10");

    // Stride-2 configuration
    for (int i = 0; i < 64; i++) begin ifm2[i] = int'($urandom_range(0, 1000)) - 500; ker2[i] = int'($urandom_range(0, 30)) - 15; end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ps2 = 32'h1;
    k = 0;
    while (!st2[1] && k < 10) begin @(negedge clk); k++; end
    t0 = cyc;
    k = 0;
    while (!st2[0] && k < 500) begin @(negedge clk); k++; end
    check("s2 done_latency", cyc - t0, 44);
    check("s2 writes", wr2, 4);
    check("s2 pix_cnt", {16'h0, st2[31:16]}, 32'd4);
    check("s2 pixel11 iFM_addr", cap_addr, 32'd48);
    ps2 = '0;
    @(negedge clk);
    check("s2 idle", {30'h0, st2[1:0]}, 32'h0);
    for (int i = 0; i < 4; i++)
      check($sformatf("s2 ofm[%0d]", i), ofm2[i], ref_o(1'b1, 0, i / 2, i % 2, 1'b0));

    check("oFM_we encoding", {31'h0, bad_we}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_os_engine.md
Name: conv_os_engine

Overview:
- Parametrised, output-stationary convolution engine for the MobileNet PL fabric.
- Computes O[m][r][c] = sum over n,kr,kc of W[m][n][kr][kc] * I[n][r*STRIDE+kr][c*STRIDE+kc].
- Accumulates each output pixel in an internal register and writes it once, so there is no read-modify-write of oFM.
- Adds stride, optional ReLU and a start/done/busy handshake with the PS over ps_control/pl_status.

Parameters:
- DATA_W, 32: word width of iFM, kernel and oFM data; also the accumulator width.
- M, 3: output channels.
- N, 3: input channels.
- K, 3: square kernel size.
- IFM_R, 4: input feature map rows.
- IFM_C, 4: input feature map columns.
- STRIDE, 1: convolution stride, ≥1.
- Derived, not overridable: OFM_R = (IFM_R-K)/STRIDE+1, OFM_C = (IFM_C-K)/STRIDE+1, T = N*K*K.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ps_control  in  32  [0] start (level), [1] relu_en, others ignored
- pl_status  out  32  [0] done, [1] busy, [31:16] pixels written this run
- iFM_addr  out  32  byte address into iFM BRAM
- iFM_rddata  in  DATA_W  iFM read data, 1-cycle latency
- iFM_wrdata  out  DATA_W  tied 0
- iFM_we  out  4  tied 0
- kernel_addr  out  32  byte address into kernel BRAM
- kernel_rddata  in  DATA_W  kernel read data, 1-cycle latency
- kernel_wrdata  out  DATA_W  tied 0
- kernel_we  out  4  tied 0
- oFM_addr  out  32  byte address into oFM BRAM
- oFM_rddata  in  DATA_W  unused
- oFM_wrdata  out  DATA_W  result word
- oFM_we  out  4  4'hF only in WRITE, else 0

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset effect: state=IDLE; all counters and acc = 0; pixel count = 0; pl_status = 0; oFM_we = 0; all addresses = 0.
- Reset mid-operation aborts the run immediately. No further writes occur.
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - Waits for ps_control[0]=1, then goes to RUN.
  - On that transition: counters m, r, c, n, kr, kc and pixel count are cleared; relu_en is latched.
- RUN (T cycles per pixel):
  - Issues one iFM/kernel address pair per cycle.
  - Inner loop order, innermost first: kc, kr, n.
  - After the pair with n=N-1, kr=K-1, kc=K-1 has been issued, go to DRAIN.
- Addresses during RUN/DRAIN, combinational from the counters:
  - iFM_addr = 4*(n*IFM_R*IFM_C + (r*STRIDE+kr)*IFM_C + c*STRIDE+kc)
  - kernel_addr = 4*(((m*N+n)*K+kr)*K+kc)
  - oFM_addr = 4*(m*OFM_R*OFM_C + r*OFM_C + c), stable from the first RUN cycle of a pixel through its WRITE.
- MAC pipeline:
  - A 1-cycle delayed valid flag and a delayed first flag track issued reads.
  - When valid: acc <= (first ? 0 : acc) + iFM_rddata*kernel_rddata.
  - Arithmetic is signed two's complement; the product is truncated to its low DATA_W bits; the accumulator wraps with no saturation.
- DRAIN (1 cycle): the last product is absorbed into acc.
- WRITE (1 cycle):
  - oFM_we = 4'hF.
  - oFM_wrdata = (relu_latched && acc[DATA_W-1]) ? 0 : acc.
  - Pixel count increments.
  - Outer loop order, innermost first: c, r, m.
  - If the last pixel (m=M-1, r=OFM_R-1, c=OFM_C-1) was just written, go to DONE; else go to RUN.
- oFM_wrdata is 0 outside WRITE.
- Pixel timing: T+2 cycles. Full run from RUN entry to DONE entry: M*OFM_R*OFM_C*(T+2) cycles.
- Status: busy=1 in RUN, DRAIN and WRITE. done=1 only in DONE.
- DONE: holds while ps_control[0]=1; goes to IDLE when ps_control[0]=0. A held start does not retrigger a run.
- Start deasserted during RUN/DRAIN/WRITE is ignored; the run completes. DONE then exits to IDLE on the next cycle.
- relu_en changes mid-run have no effect.
- The pixel count holds its value in DONE and IDLE until the next start.
- K=1 and STRIDE>1 must be supported. (IFM-K) not divisible by STRIDE truncates the trailing rows/columns.

Test Plan:
- Defaults; all iFM and kernel words = 1; start held high:
  - Each of 12 oFM words (addresses 0x00..0x2C) = 27.
  - done asserts 348 cycles after RUN entry; pl_status[31:16] = 12.
  - done holds until start is dropped, then the block returns to IDLE.
- Defaults; iFM[i] = i (word index); kernel all 1; relu off:
  - O[0][0][0] = 3*(0+1+2+4+5+6+8+9+10) + 16*9*(0+1+2) = 567; identical for m=1,2.
  - Checked against a software golden model for all 12 outputs.
- Kernel all -1; iFM all 2:
  - relu off: every output = -54 (0xFFFFFFCA).
  - relu on: every output = 0, and oFM_we is still pulsed 12 times.
- IFM_R=IFM_C=5, STRIDE=2, K=3, M=N=1:
  - OFM 2x2.
  - iFM addresses for pixel (1,1) start at byte 4*(2*5+2) = 48.
  - Exactly 4 writes.
- Assert reset for 1 cycle at RUN cycle 100 of the default run:
  - Next cycle is IDLE, oFM_we = 0, pl_status = 0.
  - A fresh start produces correct full results.
- Drop start at RUN cycle 10:
  - The run completes with all 12 writes.
  - done is high for exactly 1 cycle, then the block is in IDLE; no retrigger occurs.
